hazard_scoreboard: RTL and testbench

- Decode-stage hazard unit beside the 16-entry register file in the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Holds a shadow of destination-register info for instructions in EX and MEM.
- Compares the ID instruction's sources against that shadow and raises stall to hold IF/ID and inject a bubble into EX.
- WB-stage conflicts are excluded: the register file's write-through bypass covers them.

---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard detect against EX/MEM destination shadow.
// Define FORWARD_EN when the EX/MEM-to-EX bypass exists (load-use stalls only).
module hazard_scoreboard #(
  parameter int NREG_BITS = 4,
  parameter bit IGNORE_R0 = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NREG_BITS-1:0] id_src1,
  input  logic                 id_src1_used,
  input  logic [NREG_BITS-1:0] id_src2,
  input  logic                 id_src2_used,
  input  logic [NREG_BITS-1:0] id_dst,
  input  logic                 id_wr,
  input  logic                 id_is_load,
  input  logic                 flush,
  input  logic                 mem_hold,
  output logic                 stall,
  output logic                 ex_valid,
  output logic                 ex_wr,
  output logic                 ex_is_load,
  output logic [NREG_BITS-1:0] ex_dst,
  output logic                 mem_valid,
  output logic                 mem_wr,
  output logic [NREG_BITS-1:0] mem_dst,
  output logic [CNT_W-1:0]     stall_count
);

  function automatic logic hit(
    input logic                 v,
    input logic                 wr,
    input logic [NREG_BITS-1:0] dst,
    input logic                 used,
    input logic [NREG_BITS-1:0] src
  );
    return used && v && wr && (dst == src)
        && !(IGNORE_R0 && (src == '0));
  endfunction

  logic ex_h1, ex_h2;
  logic hz;

  assign ex_h1 = hit(ex_valid, ex_wr, ex_dst,
                     id_src1_used, id_src1);
  assign ex_h2 = hit(ex_valid, ex_wr, ex_dst,
                     id_src2_used, id_src2);

`ifdef FORWARD_EN
  // Bypass covers ALU results; only a load in EX is too late.
  assign hz = ex_is_load && (ex_h1 || ex_h2);
`else
  logic mem_h1, mem_h2;

  assign mem_h1 = hit(mem_valid, mem_wr, mem_dst,
                      id_src1_used, id_src1);
  assign mem_h2 = hit(mem_valid, mem_wr, mem_dst,
                      id_src2_used, id_src2);
  assign hz = ex_h1 || ex_h2 || mem_h1 || mem_h2;
`endif

  assign stall = !rst && id_valid && !flush
              && !mem_hold && hz;

  logic                 nx_valid;
  logic                 nx_wr;
  logic                 nx_load;
  logic [NREG_BITS-1:0] nx_dst;

  always_comb begin
    nx_valid = id_valid;
    nx_wr    = id_wr && id_valid;
    nx_load  = id_is_load && id_valid;
    nx_dst   = id_dst;
    if (flush || stall) begin
      nx_valid = 1'b0;
      nx_wr    = 1'b0;
      nx_load  = 1'b0;
      nx_dst   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_wr       <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_dst      <= '0;
      mem_valid   <= 1'b0;
      mem_wr      <= 1'b0;
      mem_dst     <= '0;
      stall_count <= '0;
    end else if (!mem_hold) begin
      mem_valid  <= ex_valid;
      mem_wr     <= ex_wr;
      mem_dst    <= ex_dst;
      ex_valid   <= nx_valid;
      ex_wr      <= nx_wr;
      ex_is_load <= nx_load;
      ex_dst     <= nx_dst;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed + random checks against a pipeline model.
// Two instances: IGNORE_R0=1 (idx 0) and IGNORE_R0=0 (idx 1).
module tb_hazard_scoreboard;
  localparam int NB = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          id_valid = 0, id_src1_used = 0;
  logic          id_src2_used = 0, id_wr = 0;
  logic          id_is_load = 0, flush = 0, mem_hold = 0;
  logic [NB-1:0] id_src1 = 0, id_src2 = 0, id_dst = 0;

  logic          st[2], exv[2], exw[2], exl[2];
  logic          memv[2], memw[2];
  logic [NB-1:0] exd[2], memd[2];
  logic [CW-1:0] cnt[2];

  hazard_scoreboard #(
    .NREG_BITS(NB), .IGNORE_R0(1'b1), .CNT_W(CW)
  ) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dst(id_dst), .id_wr(id_wr),
    .id_is_load(id_is_load), .flush(flush),
    .mem_hold(mem_hold), .stall(st[0]),
    .ex_valid(exv[0]), .ex_wr(exw[0]),
    .ex_is_load(exl[0]), .ex_dst(exd[0]),
    .mem_valid(memv[0]), .mem_wr(memw[0]),
    .mem_dst(memd[0]), .stall_count(cnt[0])
  );

  hazard_scoreboard #(
    .NREG_BITS(NB), .IGNORE_R0(1'b0), .CNT_W(CW)
  ) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dst(id_dst), .id_wr(id_wr),
    .id_is_load(id_is_load), .flush(flush),
    .mem_hold(mem_hold), .stall(st[1]),
    .ex_valid(exv[1]), .ex_wr(exw[1]),
    .ex_is_load(exl[1]), .ex_dst(exd[1]),
    .mem_valid(memv[1]), .mem_wr(memw[1]),
    .mem_dst(memd[1]), .stall_count(cnt[1])
  );

  // Model: in-flight instructions, [0]=one ahead of ID, [1]=two ahead.
  typedef struct {
    bit       v;
    bit [3:0] d;
    bit       w;
    bit       l;
  } ent_t;

  ent_t ahead[2][2];
  int   mcnt[2];
  bit   exp_st[2];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic bit model_hz(int k);
    bit       h = 0;
    bit [3:0] src[2];
    bit       use_s[2];
    src[0] = id_src1; use_s[0] = id_src1_used;
    src[1] = id_src2; use_s[1] = id_src2_used;
    for (int i = 0; i < 2; i++) begin
      if (!use_s[i]) continue;
      if (k == 0 && src[i] == 0) continue;
      for (int j = 0; j < 2; j++) begin
        ent_t p = ahead[k][j];
        if (p.v && p.w && p.d == src[i]) begin
`ifdef FORWARD_EN
          if (j == 0 && p.l) h = 1;
`else
          h = 1;
`endif
        end
      end
    end
    return !rst && id_valid && !flush && !mem_hold && h;
  endfunction

  task automatic chk(string tag, int k,
                     logic [63:0] got, logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] got %h exp %h", tag, k, got, exp);
    end
  endtask

  task automatic cyc();
    logic [63:0] e, g;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_st[k] = model_hz(k);
      chk("stall", k, 64'(st[k]), 64'(exp_st[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ahead[k][0] = '{0, 0, 0, 0};
        ahead[k][1] = '{0, 0, 0, 0};
        mcnt[k] = 0;
      end else if (!mem_hold) begin
        ahead[k][1] = ahead[k][0];
        if (flush || exp_st[k])
          ahead[k][0] = '{0, 0, 0, 0};
        else
          ahead[k][0] = '{id_valid, id_dst,
                          id_wr && id_valid,
                          id_is_load && id_valid};
        if (exp_st[k] && mcnt[k] < (1 << CW) - 1)
          mcnt[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e = 64'({ahead[k][0].v, ahead[k][0].d,
               ahead[k][0].w, ahead[k][0].l,
               ahead[k][1].v, ahead[k][1].d,
               ahead[k][1].w, CW'(mcnt[k])});
      g = 64'({exv[k], exd[k], exw[k], exl[k],
               memv[k], memd[k], memw[k], cnt[k]});
      chk("regs", k, g, e);
    end
  endtask

  task automatic set_id(bit v, bit [3:0] s1, bit u1,
                        bit [3:0] s2, bit u2,
                        bit [3:0] d, bit w, bit l);
    id_valid = v; id_src1 = s1; id_src1_used = u1;
    id_src2 = s2; id_src2_used = u2;
    id_dst = d; id_wr = w; id_is_load = l;
  endtask

  // Hold the instruction in ID while the model says it stalls.
  task automatic issue(bit [3:0] s1, bit u1,
                       bit [3:0] s2, bit u2,
                       bit [3:0] d, bit w, bit l);
    int n = 0;
    set_id(1, s1, u1, s2, u2, d, w, l);
    do begin
      cyc();
      n++;
    end while (exp_st[0] && n < 6);
    if (n >= 6) chk("issue_timeout", 0, 64'(n), 64'(0));
  endtask

  task automatic idle(int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ahead[k][0] = '{0, 0, 0, 0};
      ahead[k][1] = '{0, 0, 0, 0};
      mcnt[k] = 0;
    end
    rst = 1;
    set_id(1, 3, 1, 3, 1, 3, 1, 1);
    repeat (2) cyc();
    chk("rst_cnt", 0, 64'(cnt[0]), 64'(0));
    rst = 0;
    idle(2);
    issue(1, 1, 2, 1, 3, 1, 0);
    issue(3, 1, 1, 1, 5, 1, 0);
    idle(3);
    issue(1, 1, 2, 1, 4, 1, 1);
    issue(4, 1, 2, 1, 6, 1, 0);
    idle(3);
    issue(1, 1, 2, 1, 0, 1, 0);
    issue(0, 1, 0, 1, 9, 1, 0);
    issue(1, 1, 2, 1, 0, 1, 1);
    issue(0, 1, 1, 0, 10, 1, 0);
    idle(3);
    issue(1, 1, 2, 1, 7, 1, 0);
    set_id(1, 7, 1, 2, 1, 11, 1, 0);
    flush = 1;
    cyc();
    flush = 0;
    issue(7, 1, 2, 0, 11, 1, 0);
    idle(3);
    issue(1, 1, 2, 1, 8, 1, 1);
    set_id(1, 8, 1, 2, 1, 12, 1, 0);
    mem_hold = 1;
    repeat (3) cyc();
    mem_hold = 0;
    issue(8, 1, 2, 1, 12, 1, 0);
    idle(3);
    for (int i = 0; i < 40; i++) begin
      issue(1, 1, 2, 1, 13, 1, 1);
      issue(13, 1, 2, 1, 14, 1, 0);
    end
    idle(1);
    chk("sat", 0, 64'(cnt[0]), 64'((1 << CW) - 1));
    chk("sat", 1, 64'(cnt[1]), 64'((1 << CW) - 1));
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(49) == 0);
      flush    = ($urandom_range(7) == 0);
      mem_hold = ($urandom_range(7) == 0);
      set_id($urandom_range(3) != 0,
             4'($urandom_range(3)), 1'($urandom),
             4'($urandom_range(3)), 1'($urandom),
             4'($urandom_range(3)), 1'($urandom),
             1'($urandom));
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
